// File: rtl/linreg_engine_if.sv
// rtl/linreg_engine_if.sv - sample/result handshake bundle for linreg_engine
interface linreg_engine_if #(
    parameter int W = 20
);
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] b0;
    logic [W-1:0] b1;
    logic         sat;
    logic         err_div0;
    logic         busy;

    modport master (
        output start, in_valid, x, y, last, out_ready,
        input  in_ready, out_valid, b0, b1, sat, err_div0, busy
    );

    modport slave (
        input  start, in_valid, x, y, last, out_ready,
        output in_ready, out_valid, b0, b1, sat, err_div0, busy
    );
endinterface

// File: rtl/linreg_engine.sv
// rtl/linreg_engine.sv - streaming least-squares slope/intercept engine
module linreg_engine #(
    parameter int W    = 20,
    parameter int FRAC = 10,
    parameter int CNTW = 8
) (
    input  logic           clk,
    input  logic           rst,
    linreg_engine_if.slave bus
);
    localparam int AW = 2 * W + CNTW;
    localparam int SW = 2 * W + 2 * CNTW + 1;
    localparam int DW = SW + W;
    localparam int CW = $clog2(W);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC  = 3'd1;
    localparam logic [2:0] S_SS   = 3'd2;
    localparam logic [2:0] S_DIV1 = 3'd3;
    localparam logic [2:0] S_B0P  = 3'd4;
    localparam logic [2:0] S_DIV2 = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]      r_state;
    logic [CNTW-1:0] r_n;
    logic [AW-1:0]   r_sx, r_sy, r_sxy, r_sxx;
    logic [DW-1:0]   r_rem, r_dsh;
    logic [W-2:0]    r_q;
    logic [CW-1:0]   r_cnt;
    logic            r_neg, r_clip, r_div0;
    logic [W-1:0]    r_b0, r_b1;
    logic            r_sat, r_err;

    // Sample products, sign-extended to full accumulator width so no bits are lost
    logic [AW-1:0]   w_x_ext, w_y_ext, w_xy, w_xx;
    logic [CNTW-1:0] w_n_inc;
    logic            w_acc_end, w_restart;

    assign w_x_ext   = {{(AW-W){bus.x[W-1]}}, bus.x};
    assign w_y_ext   = {{(AW-W){bus.y[W-1]}}, bus.y};
    assign w_xy      = w_x_ext * w_y_ext;
    assign w_xx      = w_x_ext * w_x_ext;
    assign w_n_inc   = r_n + CNTW'(1);
    assign w_acc_end = bus.last || (&w_n_inc);
    assign w_restart = bus.start && ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));

    // Centred sums (exact) and the intercept numerator, all in SW-bit two's complement
    logic [SW-1:0]        w_n_s, w_sx_s, w_sy_s, w_sxy_s, w_sxx_s;
    logic [SW-1:0]        w_ssxy, w_ssxx, w_b1_s, w_b0num;
    logic signed [SW-1:0] w_b1x_sh;

    assign w_n_s    = {{(SW-CNTW){1'b0}}, r_n};
    assign w_sx_s   = {{(SW-AW){r_sx[AW-1]}}, r_sx};
    assign w_sy_s   = {{(SW-AW){r_sy[AW-1]}}, r_sy};
    assign w_sxy_s  = {{(SW-AW){r_sxy[AW-1]}}, r_sxy};
    assign w_sxx_s  = {{(SW-AW){r_sxx[AW-1]}}, r_sxx};
    assign w_ssxy   = w_n_s * w_sxy_s - w_sx_s * w_sy_s;
    assign w_ssxx   = w_n_s * w_sxx_s - w_sx_s * w_sx_s;
    assign w_b1_s   = {{(SW-W){r_b1[W-1]}}, r_b1};
    assign w_b1x_sh = $signed(w_b1_s * w_sx_s) >>> FRAC;
    assign w_b0num  = w_sy_s - w_b1x_sh;

    logic [DW-1:0] w_ld_num, w_ld_den, w_abs_num, w_abs_den;
    logic          w_ld_clip, w_ld_div0, w_ld_neg;

    // Select the dividend/divisor pair for the division about to start (slope or intercept)
    always_comb begin
        w_ld_num = '0;
        w_ld_den = '0;
        if (r_state == S_SS) begin
            w_ld_num = {{(DW-SW-FRAC){w_ssxy[SW-1]}}, w_ssxy, {FRAC{1'b0}}};
            w_ld_den = {{(DW-SW){w_ssxx[SW-1]}}, w_ssxx};
        end else begin
            w_ld_num = {{(DW-SW){w_b0num[SW-1]}}, w_b0num};
            w_ld_den = {{(DW-CNTW){1'b0}}, r_n};
        end
    end

    assign w_abs_num = w_ld_num[DW-1] ? -w_ld_num : w_ld_num;
    assign w_abs_den = w_ld_den[DW-1] ? -w_ld_den : w_ld_den;
    assign w_ld_clip = (w_abs_num >= (w_abs_den << (W - 1)));
    assign w_ld_div0 = (w_ld_den == '0);
    assign w_ld_neg  = w_ld_num[DW-1] ^ w_ld_den[DW-1];

    // Restoring divider step: compare remainder against the shifted divisor, MSB first
    logic         w_ge, w_div_last;
    logic [W-1:0] w_q_next, w_res;

    assign w_ge       = (r_rem >= r_dsh);
    assign w_q_next   = {r_q, w_ge};
    assign w_div_last = (r_cnt == CW'(W - 1));

    // Final signed result, with divide-by-zero and saturation overriding the quotient
    always_comb begin
        w_res = '0;
        if (r_div0)
            w_res = '0;
        else if (r_clip)
            w_res = r_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            w_res = r_neg ? -w_q_next : w_q_next;
    end

    // Control FSM, accumulators and shared divider datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_sxy   <= '0;
            r_sxx   <= '0;
            r_rem   <= '0;
            r_dsh   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_clip  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            if (w_restart) begin
                r_n   <= '0;
                r_sx  <= '0;
                r_sy  <= '0;
                r_sxy <= '0;
                r_sxx <= '0;
            end
            case (r_state)
                S_IDLE: if (bus.start) r_state <= S_ACC;
                S_ACC: begin
                    if (bus.in_valid) begin
                        r_sx  <= r_sx + w_x_ext;
                        r_sy  <= r_sy + w_y_ext;
                        r_sxy <= r_sxy + w_xy;
                        r_sxx <= r_sxx + w_xx;
                        r_n   <= w_n_inc;
                        if (w_acc_end) r_state <= S_SS;
                    end
                end
                S_SS, S_B0P: begin
                    r_rem   <= w_abs_num;
                    r_dsh   <= w_abs_den << (W - 1);
                    r_q     <= '0;
                    r_cnt   <= '0;
                    r_neg   <= w_ld_neg;
                    r_clip  <= w_ld_clip;
                    r_div0  <= w_ld_div0;
                    r_state <= (r_state == S_SS) ? S_DIV1 : S_DIV2;
                end
                S_DIV1, S_DIV2: begin
                    if (w_ge) r_rem <= r_rem - r_dsh;
                    r_dsh <= r_dsh >> 1;
                    r_q   <= w_q_next[W-2:0];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_div_last) r_state <= (r_state == S_DIV1) ? S_B0P : S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) r_state <= bus.start ? S_ACC : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result registers load only on the last iteration of each division
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b0  <= '0;
            r_b1  <= '0;
            r_sat <= 1'b0;
            r_err <= 1'b0;
        end else if (w_div_last && (r_state == S_DIV1)) begin
            r_b1  <= w_res;
            r_sat <= r_clip && !r_div0;
            r_err <= r_div0;
        end else if (w_div_last && (r_state == S_DIV2)) begin
            r_b0  <= w_res;
            r_sat <= r_sat || r_clip;
        end
    end

    assign bus.in_ready  = (r_state == S_ACC);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.b0        = r_b0;
    assign bus.b1        = r_b1;
    assign bus.sat       = r_sat;
    assign bus.err_div0  = r_err;
endmodule

// File: tb/tb_linreg_engine.sv
// tb/tb_linreg_engine.sv - self-checking bench for linreg_engine
module tb_linreg_engine;
    localparam int W    = 20;
    localparam int FRAC = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    linreg_engine_if #(.W(W)) bus ();
    linreg_engine_if #(.W(W)) bus2 ();

    linreg_engine #(.W(W), .FRAC(FRAC), .CNTW(8)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    linreg_engine #(.W(W), .FRAC(FRAC), .CNTW(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int qx[256];
    int qy[256];
    logic [W-1:0] exp_b0, exp_b1, got_b0, got_b1;
    logic         exp_sat, exp_err, got_sat, got_err;
    bit           exp_pending = 0;
    int           last_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    function automatic void clip_div(input logic signed [127:0] num, input logic signed [127:0] den,
                                     output logic [W-1:0] r, output logic s);
        logic signed [127:0] lim, q, t;
        lim = 128'sd1 <<< (W - 1);
        q   = num / den;
        s   = 1'b0;
        if (q >= lim) begin
            t = lim - 1;
            s = 1'b1;
        end else if (q <= -lim) begin
            t = -lim;
            s = 1'b1;
        end else begin
            t = q;
        end
        r = t[W-1:0];
    endfunction

    function automatic void model(input int n);
        logic signed [127:0] sx, sy, sxy, sxx, xi, yi, nn, ssxy, ssxx, b1s, num2;
        logic s1, s0;
        sx = 0; sy = 0; sxy = 0; sxx = 0;
        for (int i = 0; i < n; i++) begin
            xi = qx[i];
            yi = qy[i];
            sx += xi;
            sy += yi;
            sxy += xi * yi;
            sxx += xi * xi;
        end
        nn   = n;
        ssxy = nn * sxy - sx * sy;
        ssxx = nn * sxx - sx * sx;
        if (ssxx == 0) begin
            exp_b1  = '0;
            exp_err = 1'b1;
            s1      = 1'b0;
        end else begin
            exp_err = 1'b0;
            clip_div(ssxy <<< FRAC, ssxx, exp_b1, s1);
        end
        b1s  = {{(128-W){exp_b1[W-1]}}, exp_b1};
        num2 = sy - ((b1s * sx) >>> FRAC);
        clip_div(num2, nn, exp_b0, s0);
        exp_sat = s1 | s0;
    endfunction

    task automatic compare_loop();
        bit seen = 0;
        forever begin
            @(negedge clk);
            if (rst || !exp_pending) begin
                seen = 0;
            end else if (bus.out_valid) begin
                if (!seen) begin
                    seen = 1;
                    check("latency", cyc - last_edge, 2 * W + 2);
                end
                check("b1", bus.b1, exp_b1);
                check("b0", bus.b0, exp_b0);
                check("sat", bus.sat, exp_sat);
                check("err_div0", bus.err_div0, exp_err);
            end
        end
    endtask

    task automatic send_run(input int n, input bit do_start);
        int i = 0;
        int guard = 0;
        bit acc;
        model(n);
        if (do_start) begin
            bus.start = 1;
            @(posedge clk); #1 bus.start = 0;
        end
        while (i < n && guard < 400) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.x        = qx[i][W-1:0];
            bus.y        = qy[i][W-1:0];
            bus.last     = (i == n - 1);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc && i == n - 1) begin
                last_edge   = cyc + 1;
                exp_pending = 1;
            end
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        check("samples_accepted", i, n);
        bus.in_valid = 0;
        bus.last     = 0;
    endtask

    task automatic wait_result(input int hold, input bit start_during);
        int t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_seen", bus.out_valid, 1);
        got_b0 = bus.b0; got_b1 = bus.b1; got_sat = bus.sat; got_err = bus.err_div0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1 bus.start = start_during;
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1 bus.out_ready = 1; bus.start = start_during;
        @(posedge clk); #1 bus.out_ready = 0; bus.start = 0; exp_pending = 0;
    endtask

    task automatic dir_check(input string nm, input logic [W-1:0] b1, input logic [W-1:0] b0,
                             input logic s, input logic e);
        check({nm, "_model_b1"}, exp_b1, b1);
        check({nm, "_model_b0"}, exp_b0, b0);
        check({nm, "_b1"}, got_b1, b1);
        check({nm, "_b0"}, got_b0, b0);
        check({nm, "_sat"}, got_sat, s);
        check({nm, "_err"}, got_err, e);
    endtask

    task automatic load3(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
        qx[0] = x0; qy[0] = y0; qx[1] = x1; qy[1] = y1; qx[2] = x2; qy[2] = y2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc2;
        int l2;
        int t;
        logic rdy3;
        bus.start = 0; bus.in_valid = 0; bus.x = '0; bus.y = '0; bus.last = 0; bus.out_ready = 0;
        bus2.start = 0; bus2.in_valid = 0; bus2.x = '0; bus2.y = '0; bus2.last = 0; bus2.out_ready = 0;
        rst = 1;
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_b0", bus.b0, 0);
        check("rst_b1", bus.b1, 0);
        check("rst_sat", bus.sat, 0);
        check("rst_err", bus.err_div0, 0);
        rst = 0;
        @(posedge clk); #1;

        load3(32'h400, 32'hC00, 32'h800, 32'h1400, 32'hC00, 32'h1C00);
        send_run(3, 1);
        wait_result(0, 0);
        dir_check("line", 20'h00800, 20'h00400, 0, 0);

        load3(0, 32'h1000, 32'h400, 32'h800, 32'h800, 0);
        send_run(3, 1);
        wait_result(0, 0);
        dir_check("negslope", 20'hFF800, 20'h01000, 0, 0);

        qx[0] = 32'h400; qy[0] = 32'hC00;
        send_run(1, 1);
        wait_result(0, 0);
        dir_check("single", 20'h00000, 20'h00C00, 0, 1);

        qx[0] = 0; qy[0] = 0; qx[1] = 1; qy[1] = 32'h19000;
        send_run(2, 1);
        wait_result(0, 0);
        dir_check("clip", 20'h7FFFF, 20'h0C700, 1, 0);

        load3(0, 32'h1000, 32'h400, 32'h800, 32'h800, 0);
        send_run(3, 1);
        wait_result(10, 1);
        dir_check("bp", 20'hFF800, 20'h01000, 0, 0);
        @(negedge clk);
        check("bp_restart_in_ready", bus.in_ready, 1);
        check("bp_restart_busy", bus.busy, 1);
        @(posedge clk); #1;
        load3(32'h400, 32'hC00, 32'h800, 32'h1400, 32'hC00, 32'h1C00);
        send_run(3, 0);
        wait_result(0, 0);
        dir_check("bp_next", 20'h00800, 20'h00400, 0, 0);

        load3(0, 32'h1000, 32'h400, 32'h800, 32'h800, 0);
        send_run(3, 1);
        repeat (5) @(posedge clk);
        #1 exp_pending = 0;
        rst = 1;
        #1;
        check("div1rst_out_valid", bus.out_valid, 0);
        check("div1rst_busy", bus.busy, 0);
        check("div1rst_in_ready", bus.in_ready, 0);
        check("div1rst_b0", bus.b0, 0);
        check("div1rst_b1", bus.b1, 0);
        check("div1rst_sat", bus.sat, 0);
        check("div1rst_err", bus.err_div0, 0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        load3(32'h400, 32'hC00, 32'h800, 32'h1400, 32'hC00, 32'h1C00);
        send_run(3, 1);
        wait_result(0, 0);
        dir_check("after_rst", 20'h00800, 20'h00400, 0, 0);

        for (int r = 0; r < 12; r++) begin
            int n;
            bit same;
            n    = $urandom_range(2, 12);
            same = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < n; i++) begin
                qx[i] = same ? qx[0] : int'($urandom_range(0, 16383)) - 8192;
                if (i == 0) qx[0] = int'($urandom_range(0, 16383)) - 8192;
                qy[i] = int'($urandom_range(0, 400000)) - 200000;
            end
            send_run(n, 1);
            wait_result($urandom_range(0, 3), 0);
        end

        load3(32'h400, 32'hC00, 32'h800, 32'h1400, 32'hC00, 32'h1C00);
        qx[3] = 32'h1000; qy[3] = 32'h2400;
        bus2.start = 1;
        @(posedge clk); #1 bus2.start = 0;
        acc2 = 0; l2 = 0; rdy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus2.in_valid = 1;
            bus2.x = qx[i][W-1:0];
            bus2.y = qy[i][W-1:0];
            @(negedge clk);
            if (i == 3) rdy3 = bus2.in_ready;
            if (bus2.in_ready) begin
                acc2++;
                if (acc2 == 3) l2 = cyc + 1;
            end
            @(posedge clk); #1;
        end
        bus2.in_valid = 0;
        check("cnt2_accepts", acc2, 3);
        check("cnt2_ready_after_third", rdy3, 0);
        t = 0;
        @(negedge clk);
        while (!bus2.out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("cnt2_latency", cyc - l2, 2 * W + 2);
        check("cnt2_b1", bus2.b1, 20'h00800);
        check("cnt2_b0", bus2.b0, 20'h00400);
        check("cnt2_sat", bus2.sat, 0);
        @(posedge clk); #1 bus2.out_ready = 1;
        @(posedge clk); #1 bus2.out_ready = 0;
        @(negedge clk);
        check("cnt2_idle", bus2.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
